// File: rtl/i2c_cfg_target.sv
// Write-only I2C target: decodes Si5340 configuration writes into {page, reg} write events.
// Define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter on SCL and SDA.
module i2c_cfg_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h74,
  parameter logic [7:0] PAGE_REG   = 8'h01,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic        wr_valid_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [7:0]  page_o,
  output logic        busy_o,
  output logic [15:0] wr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_REG, S_DATA, S_IGNORE, S_ACK_WAIT, S_ACK_DRV
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  // Stage p0/p1: two-flop synchronizer; idle bus level is high
  logic scl_p0, scl_p1, sda_p0, sda_p1;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
    end
  end

  // Stage p2: filtered (or pass-through) line levels
  logic scl_p2, sda_p2;

`ifdef I2C_GLITCH_FILTER_EN
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FCNT_MAX = FCW'(FILTER_LEN - 1);

  logic [FCW-1:0] scl_cnt, sda_cnt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_p2  <= 1'b1;
      sda_p2  <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_p1 == scl_p2) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FCNT_MAX) begin
        scl_p2  <= scl_p1;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_p1 == sda_p2) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FCNT_MAX) begin
        sda_p2  <= sda_p1;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_p2 = scl_p1;
  assign sda_p2 = sda_p1;
`endif

  // Stage p3: previous levels for edge and START/STOP detection
  logic scl_p3, sda_p3;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_p3 <= 1'b1;
      sda_p3 <= 1'b1;
    end else begin
      scl_p3 <= scl_p2;
      sda_p3 <= sda_p2;
    end
  end

  logic scl_rise, scl_fall, bus_start, bus_stop;

  assign scl_rise  = scl_p2 & ~scl_p3;
  assign scl_fall  = ~scl_p2 & scl_p3;
  assign bus_start = scl_p2 & scl_p3 & sda_p3 & ~sda_p2;
  assign bus_stop  = scl_p2 & scl_p3 & ~sda_p3 & sda_p2;

  state_t     state_q, state_d, ret_q, ret_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q, byte_nxt, reg_ptr_q, page_q;
  logic       last_bit, shift_en, cnt_clr, oe_set, oe_clr;
  logic       busy_set, busy_clr, reg_load, data_wr;

  assign byte_nxt = {shreg_q[6:0], sda_p2};
  assign last_bit = scl_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    oe_set   = 1'b0;
    oe_clr   = 1'b0;
    busy_set = 1'b0;
    busy_clr = 1'b0;
    reg_load = 1'b0;
    data_wr  = 1'b0;
    if (bus_stop) begin
      state_d  = S_IDLE;
      oe_clr   = 1'b1;
      busy_clr = 1'b1;
    end else if (bus_start) begin
      state_d = S_ADDR;
      oe_clr  = 1'b1;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          shift_en = scl_rise;
          if (last_bit) begin
            if (byte_nxt == {SLAVE_ADDR, 1'b0}) begin
              state_d  = S_ACK_WAIT;
              ret_d    = S_REG;
              busy_set = 1'b1;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_REG: begin
          shift_en = scl_rise;
          if (last_bit) begin
            reg_load = 1'b1;
            state_d  = S_ACK_WAIT;
            ret_d    = S_DATA;
          end
        end
        S_DATA: begin
          shift_en = scl_rise;
          if (last_bit) begin
            data_wr = 1'b1;
            state_d = S_ACK_WAIT;
            ret_d   = S_DATA;
          end
        end
        // ACK is driven for exactly one SCL low-high-low window
        S_ACK_WAIT: begin
          if (scl_fall) begin
            state_d = S_ACK_DRV;
            oe_set  = 1'b1;
          end
        end
        S_ACK_DRV: begin
          if (scl_fall) begin
            state_d = ret_q;
            oe_clr  = 1'b1;
            cnt_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p4: control state
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= S_IDLE;
      ret_q     <= S_REG;
      bit_cnt_q <= '0;
      sda_oe_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      if (cnt_clr)       bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 3'd1;
      if (oe_clr)        sda_oe_o <= 1'b0;
      else if (oe_set)   sda_oe_o <= 1'b1;
      if (busy_clr)      busy_o <= 1'b0;
      else if (busy_set) busy_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (shift_en) shreg_q <= byte_nxt;
  end

  // Stage p4: write event, pointer and page tracking
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      wr_count_o <= '0;
      page_q     <= '0;
      reg_ptr_q  <= '0;
    end else begin
      wr_valid_o <= data_wr;
      if (data_wr) begin
        wr_addr_o  <= {page_q, reg_ptr_q};
        wr_data_o  <= byte_nxt;
        wr_count_o <= sat_inc16(wr_count_o);
        if (reg_ptr_q == PAGE_REG) page_q <= byte_nxt;
        reg_ptr_q  <= reg_ptr_q + 8'd1;
      end else if (reg_load) begin
        reg_ptr_q <= byte_nxt;
      end
    end
  end

  assign page_o = page_q;

endmodule

// File: tb/tb_i2c_cfg_target.sv
// Bench for i2c_cfg_target: bit-banged I2C master, transaction-level reference model.
`timescale 1ns/1ps
module tb_i2c_cfg_target;
  localparam int TQ = 10;  // quarter SCL period in clocks

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, wr_valid, busy;
  logic [15:0] wr_addr, wr_count;
  logic [7:0]  wr_data, page;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_cfg_target dut (
    .clk_i(clk), .arstn_i(arstn), .scl_i(scl), .sda_i(sda_bus),
    .sda_oe_o(sda_oe), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .page_o(page), .busy_o(busy), .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] wr_got[$];
  int          oe_hits = 0;
  int          busy_hits = 0;
  logic [15:0] ack_bits;
  logic [7:0]  tx_q[$];

  // reference model state
  logic [7:0]  m_page = 8'h00;
  logic [7:0]  m_ptr = 8'h00;
  int          m_cnt = 0;
  logic [23:0] wr_exp[$];
  logic [15:0] ack_exp;

  always @(negedge clk) begin
    if (wr_valid) wr_got.push_back({wr_addr, wr_data});
    if (sda_oe) oe_hits++;
    if (busy) busy_hits++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] got_at(input int i);
    if (i < wr_got.size()) return wr_got[i];
    return 24'hxxxxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(TQ);
    scl = 1'b1;   tick(TQ);
    sda_m = 1'b0; tick(TQ);
    scl = 1'b0;   tick(TQ);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(TQ);
    scl = 1'b1;   tick(TQ);
    sda_m = 1'b1; tick(2 * TQ);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_m = b; tick(TQ);
    scl = 1'b1;
    if (glitch) begin
      tick(TQ); scl = 1'b0; tick(1); scl = 1'b1; tick(TQ - 1);
    end else begin
      tick(2 * TQ);
    end
    scl = 1'b0; tick(TQ);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_at);
    for (int i = 7; i >= 0; i--) send_bit(b[i], (7 - i) == glitch_at);
    sda_m = 1'b1; tick(TQ);
    scl = 1'b1;   tick(TQ);
    ack_bits = {ack_bits[14:0], ~sda_bus};
    tick(TQ);
    scl = 1'b0;   tick(TQ);
  endtask

  task automatic send_txn(input int part_bits);
    i2c_start();
    ack_bits = '0;
    foreach (tx_q[i]) send_byte(tx_q[i], -1);
    for (int i = 0; i < part_bits; i++) send_bit(1'($urandom), 1'b0);
    i2c_stop();
  endtask

  task automatic set_tx(input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    tx_q.delete();
    if (n > 0) tx_q.push_back(b0);
    if (n > 1) tx_q.push_back(b1);
    if (n > 2) tx_q.push_back(b2);
    if (n > 3) tx_q.push_back(b3);
  endtask

  // Transaction-level model: address byte, pointer byte, then data bytes at ptr, ptr+1, ...
  task automatic model_txn();
    ack_exp = '0;
    foreach (tx_q[i]) ack_exp = {ack_exp[14:0], tx_q[0] == 8'hE8};
    if (tx_q[0] == 8'hE8 && tx_q.size() > 1) begin
      m_ptr = tx_q[1];
      for (int i = 2; i < tx_q.size(); i++) begin
        wr_exp.push_back({m_page, m_ptr, tx_q[i]});
        if (m_ptr == 8'h01) m_page = tx_q[i];
        m_ptr = m_ptr + 8'd1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0; tick(3);
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b exp 0", sda_oe); end
    n_vec++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", wr_valid); end
    n_vec++; if ({wr_addr, wr_data} !== 24'h0) begin n_err++; $display("FAIL reset_wr got %h exp 0", {wr_addr, wr_data}); end
    n_vec++; if ({page, busy, wr_count} !== 25'h0) begin n_err++; $display("FAIL reset_state got page %h busy %b cnt %0d exp 0", page, busy, wr_count); end
    arstn = 1'b1; tick(5);
  endtask

  task automatic test_page_write();
    int base = wr_got.size();
    set_tx(3, 8'hE8, 8'h01, 8'h0B, 8'h00); model_txn();
    i2c_start(); ack_bits = '0;
    send_byte(8'hE8, -1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL page_busy got %b exp 1", busy); end
    send_byte(8'h01, -1); send_byte(8'h0B, -1);
    i2c_stop();
    n_vec++; if (ack_bits !== 16'h0007) begin n_err++; $display("FAIL page_acks got %h exp 0007", ack_bits); end
    n_vec++; if (wr_got.size() - base !== 1) begin n_err++; $display("FAIL page_nwr got %0d exp 1", wr_got.size() - base); end
    n_vec++; if (got_at(base) !== 24'h00010B) begin n_err++; $display("FAIL page_wr got %h exp 00010b", got_at(base)); end
    n_vec++; if (page !== 8'h0B) begin n_err++; $display("FAIL page_val got %h exp 0b", page); end
    n_vec++; if (wr_count !== 16'd1) begin n_err++; $display("FAIL page_cnt got %0d exp 1", wr_count); end
  endtask

  task automatic test_burst();
    int base = wr_got.size();
    set_tx(4, 8'hE8, 8'h24, 8'h12, 8'h34); model_txn(); send_txn(0);
    n_vec++; if (ack_bits !== 16'h000F) begin n_err++; $display("FAIL burst_acks got %h exp 000f", ack_bits); end
    n_vec++; if (wr_got.size() - base !== 2) begin n_err++; $display("FAIL burst_nwr got %0d exp 2", wr_got.size() - base); end
    n_vec++; if (got_at(base) !== 24'h0B2412) begin n_err++; $display("FAIL burst_wr0 got %h exp 0b2412", got_at(base)); end
    n_vec++; if (got_at(base + 1) !== 24'h0B2534) begin n_err++; $display("FAIL burst_wr1 got %h exp 0b2534", got_at(base + 1)); end
    n_vec++; if (wr_count !== 16'd3) begin n_err++; $display("FAIL burst_cnt got %0d exp 3", wr_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy got %b exp 0", busy); end
  endtask

  task automatic test_nack();
    int base = wr_got.size();
    int oe0 = oe_hits;
    int bz0 = busy_hits;
    set_tx(3, 8'hE6, 8'h01, 8'h55, 8'h00); model_txn(); send_txn(0);
    n_vec++; if (ack_bits !== 16'h0000) begin n_err++; $display("FAIL nack_e6 got %h exp 0000", ack_bits); end
    set_tx(2, 8'hE9, 8'h01, 8'h00, 8'h00); model_txn(); send_txn(0);
    n_vec++; if (ack_bits !== 16'h0000) begin n_err++; $display("FAIL nack_e9 got %h exp 0000", ack_bits); end
    n_vec++; if (wr_got.size() - base !== 0) begin n_err++; $display("FAIL nack_nwr got %0d exp 0", wr_got.size() - base); end
    n_vec++; if (oe_hits - oe0 !== 0) begin n_err++; $display("FAIL nack_oe got %0d cycles exp 0", oe_hits - oe0); end
    n_vec++; if (busy_hits - bz0 !== 0) begin n_err++; $display("FAIL nack_busy got %0d cycles exp 0", busy_hits - bz0); end
  endtask

  task automatic test_wrap();
    int base = wr_got.size();
    set_tx(4, 8'hE8, 8'hFF, 8'hAA, 8'hBB); model_txn(); send_txn(0);
    n_vec++; if (got_at(base) !== 24'h0BFFAA) begin n_err++; $display("FAIL wrap_wr0 got %h exp 0bffaa", got_at(base)); end
    n_vec++; if (got_at(base + 1) !== 24'h0B00BB) begin n_err++; $display("FAIL wrap_wr1 got %h exp 0b00bb", got_at(base + 1)); end
    n_vec++; if (page !== 8'h0B) begin n_err++; $display("FAIL wrap_page got %h exp 0b", page); end
    n_vec++; if (wr_count !== 16'd5) begin n_err++; $display("FAIL wrap_cnt got %0d exp 5", wr_count); end
  endtask

  task automatic test_abort();
    int base = wr_got.size();
    set_tx(2, 8'hE8, 8'h30, 8'h00, 8'h00); model_txn(); send_txn(5);
    n_vec++; if (ack_bits !== 16'h0003) begin n_err++; $display("FAIL abort_acks got %h exp 0003", ack_bits); end
    n_vec++; if (wr_got.size() - base !== 0) begin n_err++; $display("FAIL abort_nwr got %0d exp 0", wr_got.size() - base); end
    set_tx(3, 8'hE8, 8'h30, 8'h77, 8'h00); model_txn(); send_txn(0);
    n_vec++; if (got_at(base) !== 24'h0B3077) begin n_err++; $display("FAIL abort_next got %h exp 0b3077", got_at(base)); end
    n_vec++; if (wr_count !== 16'd6) begin n_err++; $display("FAIL abort_cnt got %0d exp 6", wr_count); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      int base = wr_got.size();
      int ebase = wr_exp.size();
      int nd = 1 + $urandom_range(2);
      logic [7:0] a;
      logic [7:0] r;
      a = ($urandom_range(4) == 0) ? 8'($urandom) : 8'hE8;
      r = ($urandom_range(3) == 0) ? 8'h01 : 8'($urandom);
      tx_q.delete(); tx_q.push_back(a); tx_q.push_back(r);
      for (int k = 0; k < nd; k++) tx_q.push_back(8'($urandom));
      model_txn(); send_txn(0);
      n_vec++; if (ack_bits !== ack_exp) begin n_err++; $display("FAIL rand_acks t%0d got %h exp %h", t, ack_bits, ack_exp); end
      n_vec++; if (wr_got.size() - base !== wr_exp.size() - ebase) begin
        n_err++; $display("FAIL rand_nwr t%0d got %0d exp %0d", t, wr_got.size() - base, wr_exp.size() - ebase);
      end
      for (int k = 0; k < wr_exp.size() - ebase; k++) begin
        n_vec++; if (got_at(base + k) !== wr_exp[ebase + k]) begin
          n_err++; $display("FAIL rand_wr t%0d.%0d got %h exp %h", t, k, got_at(base + k), wr_exp[ebase + k]);
        end
      end
      n_vec++; if (page !== m_page) begin n_err++; $display("FAIL rand_page t%0d got %h exp %h", t, page, m_page); end
      n_vec++; if (wr_count !== 16'(m_cnt)) begin n_err++; $display("FAIL rand_cnt t%0d got %0d exp %0d", t, wr_count, m_cnt); end
    end
  endtask

  task automatic test_glitch();
    int base = wr_got.size();
    logic [7:0] d = 8'h55;
    logic [7:0] exp_d;
`ifdef I2C_GLITCH_FILTER_EN
    exp_d = d;
`else
    exp_d = {d[7:4], d[4], d[3:1]};  // glitch adds a duplicate sample of bit 4
`endif
    wr_exp.push_back({m_page, 8'h40, exp_d});
    m_ptr = 8'h41;
    if (m_cnt < 65535) m_cnt++;
    i2c_start(); ack_bits = '0;
    send_byte(8'hE8, -1); send_byte(8'h40, -1); send_byte(d, 3);
    i2c_stop();
    n_vec++; if (wr_got.size() - base !== 1) begin n_err++; $display("FAIL glitch_nwr got %0d exp 1", wr_got.size() - base); end
    n_vec++; if (got_at(base) !== {m_page, 8'h40, exp_d}) begin
      n_err++; $display("FAIL glitch_wr got %h exp %h", got_at(base), {m_page, 8'h40, exp_d});
    end
    n_vec++; if (wr_count !== 16'(m_cnt)) begin n_err++; $display("FAIL glitch_cnt got %0d exp %0d", wr_count, m_cnt); end
  endtask

  task automatic test_arst_ack();
    logic [7:0] a = 8'hE8;
    int base;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i], 1'b0);
    n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL arst_pre_oe got %b exp 1", sda_oe); end
    arstn = 1'b0;
    #1;
    n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL arst_oe got %b exp 0", sda_oe); end
    tick(2);
    n_vec++; if ({page, busy, wr_count} !== 25'h0) begin n_err++; $display("FAIL arst_state got page %h busy %b cnt %0d exp 0", page, busy, wr_count); end
    m_page = 8'h00; m_ptr = 8'h00; m_cnt = 0;
    arstn = 1'b1; tick(2);
    scl = 1'b1; tick(TQ);
    sda_m = 1'b1; tick(2 * TQ);
    base = wr_got.size();
    set_tx(3, 8'hE8, 8'h05, 8'h3C, 8'h00); model_txn(); send_txn(0);
    n_vec++; if (got_at(base) !== 24'h00053C) begin n_err++; $display("FAIL arst_next got %h exp 00053c", got_at(base)); end
    n_vec++; if (wr_count !== 16'd1) begin n_err++; $display("FAIL arst_cnt got %0d exp 1", wr_count); end
  endtask

  initial begin
    test_reset();
    test_page_write();
    test_burst();
    test_nack();
    test_wrap();
    test_abort();
    test_random();
    test_glitch();
    test_arst_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
